reg_file_param: RTL

- Parametrised successor to the single-cycle MIPS register file.
- Adds configurable data width, depth and number of read ports.
- Adds a hardwired-zero register, write-to-read bypass and a sequenced clear engine with a busy flag.
- Sits between instruction decode and the ALU operand muxes; the clear engine also serves a software/debug clear request.

---
 rtl/reg_file_param.sv | 91 +++++++++
 1 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: DEPTH entries, NUM_RD combinational read ports,
// optional hardwired zero entry, optional write-to-read bypass and a sequenced clear.
//
// state   | meaning
// S_CLEAR | zeroing one entry per edge starting at clr_idx; busy high, writes dropped
// S_IDLE  | normal operation; writes accepted, clear_req starts a new clear
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       reg_write,
  input  logic [ADDR_W-1:0]          write_reg,
  input  logic [DATA_W-1:0]          write_data,
  input  logic [NUM_RD*ADDR_W-1:0]   read_reg,
  output logic [NUM_RD*DATA_W-1:0]   read_data,
  input  logic                       clear_req,
  output logic                       busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_idx, clr_idx_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      S_CLEAR: begin
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == {ADDR_W{1'b1}}) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (clear_req) begin
          state_nxt   = S_CLEAR;
          clr_idx_nxt = '0;
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  assign busy  = (state == S_CLEAR);
  assign wr_en = (state == S_IDLE) && reg_write &&
                 !((ZERO_REG != 0) && (write_reg == '0));

  // Array has no reset; contents become defined once the first clear completes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR)
        mem[clr_idx] <= '0;
      else if (wr_en)
        mem[write_reg] <= write_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              zero_hit;
    logic              byp_hit;

    assign addr     = read_reg[k*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_REG != 0) && (addr == '0);
    assign byp_hit  = (BYPASS != 0) && reg_write && (write_reg == addr);
    assign read_data[k*DATA_W +: DATA_W] =
      busy     ? {DATA_W{1'b0}} :
      zero_hit ? {DATA_W{1'b0}} :
      byp_hit  ? write_data     :
                 mem[addr];
  end

endmodule
